// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_BURST_LEN = 4;
    localparam int STATS_W       = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: the first set request after last_grant wins.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [IW-1:0]      winner,
    output logic               any_req
);

    int   w_idx;
    logic w_found;

    always_comb begin
        winner  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = int'(last_grant) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && req[w_idx]) begin
                winner  = IW'(w_idx);
                w_found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding a single-clock FIFO write port.
// Optional per-requester word counters are enabled with FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wen,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STATS_W-1:0]    grant_words
`endif
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(BURST_LEN + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [GW-1:0]      r_grant_id;
    logic [GW-1:0]      r_last_grant;
    logic [BW-1:0]      r_beat_cnt;
    logic [GW-1:0]      w_winner;
    logic               w_any_req;
    logic               w_lane_valid;
    logic               w_wen;
    logic               w_last_beat;
    logic [DATA_WIDTH-1:0] w_lane [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign w_lane[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (GW)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .winner     (w_winner),
        .any_req    (w_any_req)
    );

    assign w_lane_valid = req_valid[r_grant_id];
    assign w_wen        = (r_state == BURST) && w_lane_valid && !fifo_full;
    assign w_last_beat  = (r_beat_cnt == BW'(BURST_LEN - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (!fifo_full && w_any_req) begin
                    w_state_next = BURST;
                end
            end
            BURST: begin
                // A dropped valid ends the burst even while the FIFO is full.
                if (!w_lane_valid || (w_wen && w_last_beat)) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_id   <= '0;
            r_beat_cnt   <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
        end else begin
            if (r_state == IDLE && w_state_next == BURST) begin
                r_grant_id <= w_winner;
                r_beat_cnt <= '0;
            end
            if (w_wen) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (r_state == BURST && w_state_next == IDLE) begin
                r_last_grant <= r_grant_id;
            end
        end
    end

    always_comb begin
        req_ready    = '0;
        fifo_data_in = '0;
        if (r_state == BURST) begin
            req_ready[r_grant_id] = !fifo_full;
            fifo_data_in          = w_lane[r_grant_id];
        end
    end

    assign fifo_wen = w_wen;
    assign grant_id = r_grant_id;
    assign busy     = (r_state == BURST);

`ifdef FIFO_WR_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
            logic [STATS_W-1:0] r_words;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_words <= '0;
                end else if (w_wen && r_grant_id == GW'(gi) && r_words != '1) begin
                    r_words <= r_words + 1'b1;
                end
            end
            assign grant_words[gi*STATS_W +: STATS_W] = r_words;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed checks of fifo_wr_arbiter against a burst-level reference model.
module tb_fifo_wr_arbiter;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int BL = 4;
    localparam int GW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_full;
    logic              fifo_wen;
    logic [DW-1:0]     fifo_data_in;
    logic [GW-1:0]     grant_id;
    logic              busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [N*16-1:0]   grant_words;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .BURST_LEN(BL)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wen     (fifo_wen),
        .fifo_data_in (fifo_data_in),
        .grant_id     (grant_id),
        .busy         (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .grant_words  (grant_words)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: who owns the FIFO, how many words taken, who went last.
    bit m_busy;
    int m_owner;
    int m_beats;
    int m_last;
    int m_words [N];

    // Monitor bookkeeping for directed scenarios.
    int grant_log [$];
    bit prev_busy;
    int wen_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_next(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_beats = 0;
        m_last  = N - 1;
        foreach (m_words[i]) m_words[i] = 0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model on the edge.
    task automatic step();
        logic [N-1:0]  e_ready;
        logic          e_wen;
        logic [DW-1:0] e_data;
        @(negedge clk);
        e_ready = '0;
        e_wen   = 1'b0;
        e_data  = '0;
        if (m_busy) begin
            e_ready[m_owner] = !fifo_full;
            e_wen            = req_valid[m_owner] && !fifo_full;
            e_data           = req_data[m_owner*DW +: DW];
        end
        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("fifo_wen", 64'(fifo_wen), 64'(e_wen));
        chk("fifo_data_in", 64'(fifo_data_in), 64'(e_data));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("grant_id", 64'(grant_id), 64'(m_owner));
`ifdef FIFO_WR_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("grant_words", 64'(grant_words[i*16 +: 16]), 64'(m_words[i]));
`endif
        if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
        prev_busy = busy;
        if (fifo_wen) begin
            wen_cnt++;
            $display("wr  t=%0t req=%0d data=%h", $time, grant_id, fifo_data_in);
        end
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (!m_busy) begin
            if (!fifo_full && |req_valid) begin
                m_owner = rr_next(req_valid);
                m_beats = 0;
                m_busy  = 1;
            end
        end else if (!req_valid[m_owner]) begin
            m_busy = 0;
            m_last = m_owner;
        end else if (!fifo_full) begin
            m_beats++;
            if (m_words[m_owner] < 65535) m_words[m_owner]++;
            if (m_beats == BL) begin
                m_busy = 0;
                m_last = m_owner;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic rand_data();
        req_data = {$urandom, $urandom};
    endtask

    initial begin
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        int guard;
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        prev_busy = 1'b0;
        wen_cnt   = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        do_reset();

        // All requesters valid, never full: grants 0,1,2,3,0 with 4 words each.
        grant_log.delete();
        wen_cnt   = 0;
        req_valid = '1;
        for (int c = 0; c < 25; c++) begin
            rand_data();
            step();
        end
        chk("allvalid_bursts", 64'(grant_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk("allvalid_order", 64'(grant_log[i]), 64'(exp_seq[i]));
        chk("allvalid_words", 64'(wen_cnt), 64'd20);

        // Early drop: requester 2 alone, valid for two accepted words.
        req_valid = '0;
        do_reset();
        wen_cnt   = 0;
        req_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            rand_data();
            step();
        end
        req_valid = '0;
        step();
        step();
        chk("drop_words", 64'(wen_cnt), 64'd2);
        chk("drop_idle", 64'(busy), 64'd0);
        req_valid = 4'b1111;
        step();
        step();
        chk("drop_next_grant", 64'(grant_id), 64'd3);

        // Full for three cycles mid-burst: burst still delivers four words.
        req_valid = '0;
        do_reset();
        wen_cnt   = 0;
        req_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            rand_data();
            step();
        end
        fifo_full = 1'b1;
        repeat (3) step();
        fifo_full = 1'b0;
        guard = 0;
        while (busy && guard < 20) begin
            step();
            guard++;
        end
        chk("full_mid_words", 64'(wen_cnt), 64'd4);

        // Full while idle: no arbitration until it clears.
        req_valid = '0;
        do_reset();
        fifo_full = 1'b1;
        req_valid = 4'b0010;
        repeat (3) step();
        chk("full_idle_busy", 64'(busy), 64'd0);
        fifo_full = 1'b0;
        step();
        step();
        chk("full_idle_grant", 64'(grant_id), 64'd1);

        // Reset after word 2 of requester 3's burst: requester 0 wins next.
        req_valid = '0;
        do_reset();
        req_valid = 4'b1000;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 4'b1001;
        step();
        step();
        chk("rst_mid_grant", 64'(grant_id), 64'd0);

`ifdef FIFO_WR_ARB_STATS_EN
        // Ten words from requester 1 show up only in lane 1.
        req_valid = '0;
        do_reset();
        req_valid = 4'b0010;
        guard = 0;
        while (m_words[1] < 10 && guard < 50) begin
            rand_data();
            step();
            guard++;
        end
        req_valid = '0;
        step();
        chk("stats_lane1", 64'(grant_words[16 +: 16]), 64'd10);
        chk("stats_lane0", 64'(grant_words[0 +: 16]), 64'd0);
`endif

        // Randomized traffic with sticky valids, sporadic full and reset.
        req_valid = '0;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(3) == 0) req_valid[i] = ~req_valid[i];
            fifo_full = ($urandom_range(4) == 0);
            reset     = ($urandom_range(99) == 0);
            rand_data();
            step();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
